// File: rtl/demux2e_stream_pkg.sv
// Shared route-select encodings and default sizing for the demux2e_stream slice.
package demux2e_stream_pkg;

   localparam logic [1:0] SEL_DROP = 2'b00;
   localparam logic [1:0] SEL_OUT0 = 2'b01;
   localparam logic [1:0] SEL_OUT1 = 2'b10;
   localparam logic [1:0] SEL_ERR  = 2'b11;

   localparam int CNT_W = 8;

endpackage

// File: rtl/demux2e_stream_skid2.sv
// Two-entry FIFO that buffers one output port of the stream demux.
// The full flag is registered so the upstream ready never sees this port's rdy.
module stream_skid2 #(
   parameter int upper = 31,
   parameter int lower = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [upper:lower] data_in,
   output logic               full,
   output logic               vld,
   input  logic               rdy,
   output logic [upper:lower] data_out
);

   localparam int width = upper - lower + 1;

   logic [width-1:0] mem_r [2];
   logic             wr_ptr_r;
   logic             rd_ptr_r;
   logic [1:0]       count_r;
   logic             full_r;
   logic             vld_r;
   logic [1:0]       count_next_s;
   logic             push_s;
   logic             pop_s;

   // A push into a full FIFO is ignored even if a pop frees a slot this cycle.
   assign push_s = push & ~full_r;
   assign pop_s  = vld_r & rdy;

   // Occupancy update from the push/pop pair.
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + 2'd1;
         2'b01:   count_next_s = count_r - 2'd1;
         default: count_next_s = count_r;
      endcase
   end

   // Storage, pointers and registered status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_r[0] <= {width{1'b0}};
         mem_r[1] <= {width{1'b0}};
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
         full_r   <= 1'b0;
         vld_r    <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
         end
         wr_ptr_r <= wr_ptr_r ^ push_s;
         rd_ptr_r <= rd_ptr_r ^ pop_s;
         count_r  <= count_next_s;
         full_r   <= (count_next_s == 2'd2);
         vld_r    <= (count_next_s != 2'd0);
      end
   end

   assign full     = full_r;
   assign vld      = vld_r;
   assign data_out = mem_r[rd_ptr_r];

endmodule

// File: rtl/demux2e_stream.sv
// 1-to-2 valid/ready stream demux with one-hot route select, per-port skid FIFOs,
// a saturating drop counter and a sticky multi-hot error flag.
module demux2e_stream
   import demux2e_stream_pkg::*;
#(
   parameter int upper = 31,
   parameter int lower = 0,
   parameter int cnt_w = CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_vld,
   output logic               in_rdy,
   input  logic [1:0]         in_sel,
   input  logic [upper:lower] in_data,
   output logic               out0_vld,
   input  logic               out0_rdy,
   output logic [upper:lower] out0_data,
   output logic               out1_vld,
   input  logic               out1_rdy,
   output logic [upper:lower] out1_data,
   output logic [cnt_w-1:0]   drop_cnt,
   output logic               err_multihot
);

   logic             full0_s;
   logic             full1_s;
   logic             in_rdy_s;
   logic             push0_s;
   logic             push1_s;
   logic             drop_s;
   logic             multi_s;
   logic [cnt_w-1:0] drop_cnt_r;
   logic             err_multihot_r;

   // Ready depends only on the select and registered full flags; an unknown
   // select on a valid beat propagates X so it stands out in simulation.
   always_comb begin
      in_rdy_s = 1'b1;
      case (in_sel)
         SEL_OUT0:          in_rdy_s = ~full0_s;
         SEL_OUT1:          in_rdy_s = ~full1_s;
         SEL_DROP, SEL_ERR: in_rdy_s = 1'b1;
         default:           in_rdy_s = in_vld ? 1'bx : 1'b1;
      endcase
   end

   assign in_rdy  = in_rdy_s;
   assign push0_s = in_vld & ~full0_s & (in_sel == SEL_OUT0);
   assign push1_s = in_vld & ~full1_s & (in_sel == SEL_OUT1);
   assign drop_s  = in_vld & ((in_sel == SEL_DROP) | (in_sel == SEL_ERR));
   assign multi_s = in_vld & (in_sel == SEL_ERR);

   // Drop counter saturates at all-ones; the error flag clears only on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_r     <= {cnt_w{1'b0}};
         err_multihot_r <= 1'b0;
      end else begin
         if (drop_s && (drop_cnt_r != {cnt_w{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + {{(cnt_w-1){1'b0}}, 1'b1};
         end
         if (multi_s) begin
            err_multihot_r <= 1'b1;
         end
      end
   end

   assign drop_cnt     = drop_cnt_r;
   assign err_multihot = err_multihot_r;

   stream_skid2 #(.upper(upper), .lower(lower)) u_fifo0 (
      .clk      (clk),
      .reset    (reset),
      .push     (push0_s),
      .data_in  (in_data),
      .full     (full0_s),
      .vld      (out0_vld),
      .rdy      (out0_rdy),
      .data_out (out0_data)
   );

   stream_skid2 #(.upper(upper), .lower(lower)) u_fifo1 (
      .clk      (clk),
      .reset    (reset),
      .push     (push1_s),
      .data_in  (in_data),
      .full     (full1_s),
      .vld      (out1_vld),
      .rdy      (out1_rdy),
      .data_out (out1_data)
   );

endmodule

// File: doc/demux2e_stream.md
Name: demux2e_stream

Overview:
- 1-to-2 stream demultiplexer with one-hot route select; the steering counterpart of the AND/OR one-hot 2:1 mux used in the test harness datapath.
- Accepts one valid/ready input stream and routes each beat to output 0 or output 1.
- Each output is buffered by a 2-entry skid FIFO, so full throughput is sustained with no combinational path from out*_rdy to in_rdy.
- Zero-hot and multi-hot selects drop the beat: zero-hot counts as a drop; multi-hot counts as a drop and raises a sticky error.

Parameters:
- upper, 31, MSB index of the data bus.
- lower, 0, LSB index of the data bus.
- width, upper-lower+1, data width (derived; not overridden).
- cnt_w, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_vld  input  1  input beat valid.
- in_rdy  output  1  input beat accepted when in_vld & in_rdy.
- in_sel  input  2  one-hot route: 2'b01 routes to out0, 2'b10 routes to out1; 2'b00 drops; 2'b11 drops with error.
- in_data  input  [upper:lower]  input payload.
- out0_vld  output  1  out0 beat valid.
- out0_rdy  input  1  out0 consumer ready.
- out0_data  output  [upper:lower]  out0 payload.
- out1_vld  output  1  out1 beat valid.
- out1_rdy  input  1  out1 consumer ready.
- out1_data  output  [upper:lower]  out1 payload.
- drop_cnt  output  cnt_w  count of dropped beats (zero-hot plus multi-hot); saturates at all-ones.
- err_multihot  output  1  sticky flag; set on any accepted multi-hot beat.

Behaviour:
- Reset (synchronous, active-high) empties both FIFOs and clears out0_vld, out1_vld, out0_data, out1_data, drop_cnt and err_multihot to 0.
- Reset asserted mid-transfer discards all buffered beats; no output is presented in the cycle after reset.
- full0 and full1 are registered occupancy flags (count == 2).
- in_rdy is combinational from in_sel and the registered flags only:
  - 2'b01: in_rdy = ~full0
  - 2'b10: in_rdy = ~full1
  - 2'b00 or 2'b11: in_rdy = 1 (drop path never stalls)
  - X/Z on in_sel while in_vld=1: in_rdy = X (simulation visibility, matching the one-hot mux convention).
- A push occurs on in_vld & in_rdy & a valid one-hot select; the beat is written into the selected FIFO.
- Latency: a beat accepted in cycle N is visible on outX_vld/outX_data in cycle N+1.
- outX_vld = FIFO X non-empty; outX_data = FIFO X head. Data is held stable while outX_vld & ~outX_rdy.
- A pop occurs on outX_vld & outX_rdy.
- Full FIFO: a push is refused (in_rdy=0 for that route) even if a pop happens in the same cycle; the freed slot is usable the next cycle.
- With 2 entries, steady-state throughput is 1 beat/cycle per output while the consumer holds rdy=1.
- Simultaneous push and pop on a FIFO with count 1: count stays 1; the new data becomes head in the next cycle.
- Order is preserved within each output; there is no ordering relation between out0 and out1.
- Drop: on in_vld & (in_sel==2'b00 | in_sel==2'b11), the beat is consumed, no FIFO changes, and drop_cnt increments, holding at 2^cnt_w-1.
- In addition, in_sel==2'b11 sets err_multihot, which clears only on reset.
- in_vld=0: in_sel and in_data are ignored, and no counter or flag changes.

Decomposition:
- Shared package holds:
  - route constants SEL_OUT0=2'b01, SEL_OUT1=2'b10, SEL_DROP=2'b00
  - default CNT_W=8
- One sub-module, stream_skid2: parameterised on upper/lower; 2-entry FIFO with push/data_in/full, and vld/rdy/data_out on the read side. Instantiated twice.
- Route decode, in_rdy generation, drop counter and error flag live in the top.

Test Plan:
- Reset then idle: all outputs 0. Drive one beat sel=01, data=0xA5A5A5A5 -> in_rdy=1; out0_vld=1 with that data the next cycle; out1_vld stays 0.
- Backpressure: out1_rdy=0; push 0x1, 0x2, 0x3 with sel=10 -> first two accepted, in_rdy=0 on the third. Release out1_rdy -> 0x1, 0x2 drain in order, 0x3 accepted the cycle after the first pop.
- Full throughput: both rdy=1; alternate sel 01/10 for 100 beats -> every beat accepted, each appears exactly 1 cycle later on the correct port, no bubbles.
- Drops: 3 beats sel=00, then 1 beat sel=11 -> no output valid; drop_cnt=4; err_multihot=1 stays set; a 2'b01 beat still routes normally afterwards.
- Saturation: 300 zero-hot beats with cnt_w=8 -> drop_cnt holds 255.
- Mid-operation reset: both FIFOs full, assert reset for 1 cycle -> next cycle both outX_vld=0, drop_cnt=0, err_multihot=0, and in_rdy=1 for either route.
